// File: rtl/return_addr_stack.sv
// Return-address stack: LIFO of PC return addresses with a registered pop
// result, a one-cycle valid strobe, occupancy status and sticky error flags.
module return_addr_stack #(
   parameter int unsigned word_size = 8,
   parameter int unsigned depth     = 8,
   parameter int unsigned ptr_size  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [word_size-1:0]  data_in,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clr_err,
   output logic [word_size-1:0]  top,
   output logic [word_size-1:0]  ret_addr,
   output logic                  ret_valid,
   output logic [ptr_size:0]     count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned cnt_w = ptr_size + 1;

   logic [word_size-1:0] mem_q [depth];
   logic [word_size-1:0] mem_d [depth];
   logic [cnt_w-1:0]     count_q, count_d;
   logic [word_size-1:0] ret_addr_q, ret_addr_d;
   logic                 ret_valid_q, ret_valid_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   logic                 is_empty, is_full;
   logic [ptr_size-1:0]  top_idx;
   logic [ptr_size-1:0]  push_idx;
   logic [word_size-1:0] top_val;

   // Status decode and top-of-stack read from registered storage
   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == cnt_w'(depth));
      top_idx  = ptr_size'(count_q - cnt_w'(1));
      push_idx = ptr_size'(count_q);
      top_val  = is_empty ? '0 : mem_q[top_idx];
   end

   // Next-state decode of {push,pop}
   always_comb begin
      mem_d       = mem_q;
      count_d     = count_q;
      ret_addr_d  = ret_addr_q;
      ret_valid_d = 1'b0;
      overflow_d  = clr_err ? 1'b0 : overflow_q;
      underflow_d = clr_err ? 1'b0 : underflow_q;

      unique case ({push, pop})
         2'b10: begin
            if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               mem_d[push_idx] = data_in;
               count_d         = count_q + cnt_w'(1);
            end
         end
         2'b01: begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else begin
               ret_addr_d  = top_val;
               ret_valid_d = 1'b1;
               count_d     = count_q - cnt_w'(1);
            end
         end
         2'b11: begin
            // Replace: return then call in one cycle; on empty it degrades to a push
            if (is_empty) begin
               mem_d[push_idx] = data_in;
               count_d         = cnt_w'(1);
               underflow_d     = 1'b1;
            end else begin
               ret_addr_d      = top_val;
               ret_valid_d     = 1'b1;
               mem_d[top_idx]  = data_in;
            end
         end
         default: begin
         end
      endcase

      if (rst) begin
         mem_d       = mem_q;
         count_d     = '0;
         ret_addr_d  = '0;
         ret_valid_d = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   // Control and result registers (reset folded into next-state logic)
   always_ff @(posedge clk) begin
      count_q     <= count_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
   end

   // Entry storage, not reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign top       = top_val;
   assign ret_addr  = ret_addr_q;
   assign ret_valid = ret_valid_q;
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack.
module tb_return_addr_stack;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       push, pop, clr_err;
   logic [7:0] top, ret_addr;
   logic       ret_valid, empty, full, overflow, underflow;
   logic [3:0] count;

   int tests = 0;
   int fails = 0;

   return_addr_stack #(.word_size(8), .depth(8), .ptr_size(3)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop),
      .clr_err(clr_err), .top(top), .ret_addr(ret_addr), .ret_valid(ret_valid),
      .count(count), .empty(empty), .full(full), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; push = 1'b1; pop = 1'b0; clr_err = 1'b0; data_in = 8'hAA;
      repeat (2) tick();
      tests++; if (count !== 4'd0)   begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
      tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
      tests++; if (full !== 1'b0)    begin fails++; $display("FAIL reset_full got %b exp 0", full); end
      tests++; if (top !== 8'h00)    begin fails++; $display("FAIL reset_top got %h exp 00", top); end
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL reset_ret_valid got %b exp 0", ret_valid); end
      tests++; if (ret_addr !== 8'h00) begin fails++; $display("FAIL reset_ret_addr got %h exp 00", ret_addr); end
      tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got %b exp 0", underflow); end
      rst = 1'b0; push = 1'b0;
   endtask

   task automatic test_lifo();
      logic [7:0] vals [3] = '{8'h10, 8'h20, 8'h30};
      for (int i = 0; i < 3; i++) begin
         data_in = vals[i]; push = 1'b1;
         tick();
      end
      push = 1'b0;
      tests++; if (count !== 4'd3) begin fails++; $display("FAIL lifo_count got %0d exp 3", count); end
      tests++; if (top !== 8'h30)  begin fails++; $display("FAIL lifo_top got %h exp 30", top); end
      pop = 1'b1;
      for (int i = 2; i >= 0; i--) begin
         tick();
         tests++; if (ret_valid !== 1'b1) begin fails++; $display("FAIL lifo_pop_valid[%0d] got %b exp 1", i, ret_valid); end
         tests++; if (ret_addr !== vals[i]) begin fails++; $display("FAIL lifo_pop_addr[%0d] got %h exp %h", i, ret_addr, vals[i]); end
         tests++; if (count !== 4'(i)) begin fails++; $display("FAIL lifo_pop_count[%0d] got %0d exp %0d", i, count, i); end
      end
      pop = 1'b0;
      tick();
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL lifo_valid_drop got %b exp 0", ret_valid); end
      tests++; if (empty !== 1'b1)     begin fails++; $display("FAIL lifo_empty got %b exp 1", empty); end
      tests++; if (top !== 8'h00)      begin fails++; $display("FAIL lifo_empty_top got %h exp 00", top); end
      tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL lifo_no_underflow got %b exp 0", underflow); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) begin
         data_in = 8'(i); push = 1'b1;
         tick();
      end
      tests++; if (full !== 1'b1)  begin fails++; $display("FAIL ovf_full got %b exp 1", full); end
      tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count8 got %0d exp 8", count); end
      tests++; if (top !== 8'h08)  begin fails++; $display("FAIL ovf_top8 got %h exp 08", top); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b exp 0", overflow); end
      data_in = 8'hFF;
      tick();
      push = 1'b0;
      tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count_hold got %0d exp 8", count); end
      tests++; if (top !== 8'h08)  begin fails++; $display("FAIL ovf_top_hold got %h exp 08", top); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", overflow); end
      // Replace while full is legal and must not flag overflow again after a clear
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      push = 1'b1; pop = 1'b1; data_in = 8'h88;
      tick();
      push = 1'b0; pop = 1'b0;
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_replace_full got %b exp 0", overflow); end
      tests++; if (ret_addr !== 8'h08) begin fails++; $display("FAIL ovf_replace_ret got %h exp 08", ret_addr); end
      tests++; if (top !== 8'h88) begin fails++; $display("FAIL ovf_replace_top got %h exp 88", top); end
      // Re-trigger overflow, then pop and confirm it stays sticky
      push = 1'b1; data_in = 8'hFE; tick(); push = 1'b0;
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tests++; if (ret_addr !== 8'h88) begin fails++; $display("FAIL ovf_pop_addr got %h exp 88", ret_addr); end
      tests++; if (count !== 4'd7) begin fails++; $display("FAIL ovf_pop_count got %0d exp 7", count); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
      tick();
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky_idle got %b exp 1", overflow); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", overflow); end
      pop = 1'b1;
      repeat (7) tick();
      pop = 1'b0;
      tests++; if (ret_addr !== 8'h01) begin fails++; $display("FAIL ovf_drain_last got %h exp 01", ret_addr); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_drain_empty got %b exp 1", empty); end
   endtask

   task automatic test_underflow();
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL unf_valid got %b exp 0", ret_valid); end
      tests++; if (count !== 4'd0)     begin fails++; $display("FAIL unf_count got %0d exp 0", count); end
      tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_set got %b exp 1", underflow); end
      tests++; if (ret_addr !== 8'h01) begin fails++; $display("FAIL unf_ret_hold got %h exp 01", ret_addr); end
      clr_err = 1'b1;
      tick();
      tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL unf_clear got %b exp 0", underflow); end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_set_wins got %b exp 1", underflow); end
      tick();
      clr_err = 1'b0;
      tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL unf_clear2 got %b exp 0", underflow); end
   endtask

   task automatic test_replace();
      push = 1'b1;
      data_in = 8'h40; tick();
      data_in = 8'h50; tick();
      pop = 1'b1; data_in = 8'h77;
      tick();
      push = 1'b0; pop = 1'b0;
      tests++; if (ret_valid !== 1'b1) begin fails++; $display("FAIL rep_valid got %b exp 1", ret_valid); end
      tests++; if (ret_addr !== 8'h50) begin fails++; $display("FAIL rep_addr got %h exp 50", ret_addr); end
      tests++; if (count !== 4'd2)     begin fails++; $display("FAIL rep_count got %0d exp 2", count); end
      tests++; if (top !== 8'h77)      begin fails++; $display("FAIL rep_top got %h exp 77", top); end
      tick();
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL rep_valid_pulse got %b exp 0", ret_valid); end
      pop = 1'b1;
      tick();
      tests++; if (ret_addr !== 8'h77) begin fails++; $display("FAIL rep_pop1 got %h exp 77", ret_addr); end
      tick();
      pop = 1'b0;
      tests++; if (ret_addr !== 8'h40) begin fails++; $display("FAIL rep_pop2 got %h exp 40", ret_addr); end
      tests++; if (empty !== 1'b1)     begin fails++; $display("FAIL rep_empty got %b exp 1", empty); end
   endtask

   task automatic test_replace_empty();
      push = 1'b1; pop = 1'b1; data_in = 8'h77;
      tick();
      push = 1'b0; pop = 1'b0;
      tests++; if (count !== 4'd1)     begin fails++; $display("FAIL repe_count got %0d exp 1", count); end
      tests++; if (top !== 8'h77)      begin fails++; $display("FAIL repe_top got %h exp 77", top); end
      tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL repe_underflow got %b exp 1", underflow); end
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL repe_valid got %b exp 0", ret_valid); end
      clr_err = 1'b1; pop = 1'b1;
      tick();
      clr_err = 1'b0; pop = 1'b0;
      tests++; if (ret_addr !== 8'h77) begin fails++; $display("FAIL repe_pop got %h exp 77", ret_addr); end
   endtask

   task automatic test_reset_mid_pop();
      push = 1'b1;
      data_in = 8'h11; tick();
      data_in = 8'h22; tick();
      push = 1'b0;
      pop = 1'b1; rst = 1'b1;
      tick();
      pop = 1'b0; rst = 1'b0;
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL rstpop_valid got %b exp 0", ret_valid); end
      tests++; if (count !== 4'd0)     begin fails++; $display("FAIL rstpop_count got %0d exp 0", count); end
      tests++; if (ret_addr !== 8'h00) begin fails++; $display("FAIL rstpop_addr got %h exp 00", ret_addr); end
      tests++; if (top !== 8'h00)      begin fails++; $display("FAIL rstpop_top got %h exp 00", top); end
      tick();
      tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL rstpop_valid_late got %b exp 0", ret_valid); end
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00;
      test_reset();
      test_lifo();
      test_overflow();
      test_underflow();
      test_replace();
      test_replace_empty();
      test_reset_mid_pop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- LIFO return-address stack for the 8-bit processor core, working in the opposite direction to the program counter.
- On a call, the controller pushes the PC-derived return address into the stack.
- On a return, the controller pops the stack. The popped address is presented as a registered value with a one-cycle valid strobe, which the PC uses as its load data.
- Also provides empty/full status, an occupancy count and sticky overflow/underflow error flags to the control unit.

Parameters:
- word_size, 8, width of each stored address; matches the PC width.
- depth, 8, number of entries; must be a power of two, at least 2.
- ptr_size, 3, log2(depth); sets the pointer width. The occupancy count is ptr_size+1 bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  word_size  return address to push (PC value to resume at).
- push  input  1  push request; sampled on the rising edge of clk.
- pop  input  1  pop request; sampled on the rising edge of clk.
- clr_err  input  1  clears the sticky overflow/underflow flags.
- top  output  word_size  current top-of-stack entry, combinational read of registered storage; 0 when empty.
- ret_addr  output  word_size  registered copy of the entry removed by the last successful pop.
- ret_valid  output  1  one-cycle strobe; high in the cycle after a successful pop.
- count  output  ptr_size+1  number of valid entries, 0..depth.
- empty  output  1  count == 0.
- full  output  1  count == depth.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- One clock, clk. rst is synchronous and active-high, and is sampled only at the rising edge of clk.
- Reset state: count=0, stack pointer=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0, empty=1, full=0, top=0. Storage contents need not be reset.
- rst has priority over push, pop and clr_err in the same cycle.
- Reset mid-operation discards all entries. A ret_valid that would have asserted in the next cycle is suppressed.
- Operations are decoded from {push,pop} each cycle:
  - 00, idle: no state change; ret_valid=0.
  - 10, push:
    - Not full: write data_in at index count, count+1.
    - Full: no write, count unchanged, overflow<=1.
    - ret_valid=0.
  - 01, pop:
    - Not empty: ret_addr<=top, ret_valid<=1 next cycle, count-1.
    - Empty: no change to count/ret_addr, underflow<=1, ret_valid=0.
  - 11, replace (return immediately followed by call):
    - Not empty: ret_addr<=old top, ret_valid<=1, top entry overwritten with data_in, count unchanged.
    - Empty: acts as push of data_in (count becomes 1), underflow<=1, ret_valid=0.
    - Full: replace is legal; overflow is not set.
- Latency: pop at edge N; ret_addr and ret_valid are valid during the cycle after edge N. ret_valid is exactly one cycle wide per successful pop.
  - Back-to-back pops produce consecutive ret_valid pulses with successive entries.
- top reflects updated storage/count immediately after each edge.
- count arithmetic never wraps: it is saturated/guarded by the full and empty checks above.
- clr_err clears both sticky flags at the edge.
  - If an error condition occurs in the same cycle as clr_err, the flag is set (set wins).
- Flags do not block operation; after overflow or underflow the stack keeps working normally.

Test Plan:
- Reset: assert rst for 2 cycles with push=1 and data_in=8'hAA -> count=0, empty=1, top=0, ret_valid=0, overflow=0.
- LIFO order:
  - Push 8'h10, 8'h20, 8'h30 -> count=3, top=8'h30.
  - Pop three times back-to-back -> ret_addr 8'h30, 8'h20, 8'h10 on three consecutive ret_valid cycles; then empty=1.
- Full/overflow:
  - Push 8 values 8'h01..8'h08 -> full=1, count=8.
  - Push 8'hFF -> count stays 8, top=8'h08, overflow=1.
  - Pop -> ret_addr=8'h08; overflow stays 1 until clr_err.
- Underflow: pop while empty -> ret_valid stays 0, count=0, underflow=1; clr_err pulse -> underflow=0.
- Replace:
  - With stack holding 8'h40, 8'h50, drive push=pop=1 with data_in=8'h77 -> ret_addr=8'h50 with ret_valid=1, count=2, top=8'h77.
  - Same stimulus on an empty stack -> count=1, top=8'h77, underflow=1, ret_valid=0.
- Reset mid-pop: pop with count=2 and rst=1 in the same cycle -> next cycle ret_valid=0, count=0, ret_addr=0.
